// File: rtl/averager_counter_if.sv
// Signal bundle between the averager sequencer and the accumulator/BRAM side.
// The master is the sequencer: it takes the sample strobe and frame settings and drives the BRAM controls.
interface averager_counter_if #(
  parameter int FAST_COUNT_WIDTH = 5,
  parameter int SLOW_COUNT_WIDTH = 10
);
  logic                        clken;
  logic [FAST_COUNT_WIDTH-1:0] count_max;
  logic                        avg_on;
  logic                        clr_fback;
  logic                        ready;
  logic                        wen;
  logic [SLOW_COUNT_WIDTH-1:0] n_avg;
  logic                        avg_on_out;
  logic [FAST_COUNT_WIDTH+1:0] address;

  modport master (
    input  clken, count_max, avg_on,
    output clr_fback, ready, wen, n_avg, avg_on_out, address
  );

  modport slave (
    output clken, count_max, avg_on,
    input  clr_fback, ready, wen, n_avg, avg_on_out, address
  );
endinterface

// File: rtl/averager_counter.sv
// Address/control sequencer for a BRAM waveform averager.
// A fast counter sweeps sample indices within a frame, and a slow counter tallies the completed frames.
module averager_counter #(
  parameter int FAST_COUNT_WIDTH = 5,
  parameter int SLOW_COUNT_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  restart,
  averager_counter_if.master    bus
);

  localparam logic [SLOW_COUNT_WIDTH-1:0] N_AVG_MAX = '1;
  localparam logic [SLOW_COUNT_WIDTH-1:0] N_AVG_ONE = SLOW_COUNT_WIDTH'(1);

  // Power-up values match what a restart produces.
  logic [FAST_COUNT_WIDTH-1:0] cnt        = '0;
  logic                        first      = 1'b1;
  logic                        clr_fback  = 1'b1;
  logic                        ready      = 1'b0;
  logic                        wen        = 1'b0;
  logic [SLOW_COUNT_WIDTH-1:0] n_avg      = '0;
  logic                        avg_on_out = 1'b0;
  logic [FAST_COUNT_WIDTH+1:0] address    = '0;

  always_ff @(posedge clk) begin
    if (restart) begin
      cnt        <= '0;
      n_avg      <= '0;
      ready      <= 1'b0;
      wen        <= 1'b0;
      address    <= '0;
      first      <= 1'b1;
      clr_fback  <= 1'b1;
      avg_on_out <= bus.avg_on;
    end else if (bus.clken) begin
      address   <= {cnt, 2'b00};
      wen       <= 1'b1;
      clr_fback <= first;
      // A greater-or-equal test also ends a frame early when count_max drops below the current index.
      if (cnt >= bus.count_max) begin
        cnt   <= '0;
        ready <= 1'b1;
        if (avg_on_out) begin
          first <= 1'b0;
          if (n_avg != N_AVG_MAX) begin
            n_avg <= n_avg + N_AVG_ONE;
          end
        end else begin
          first <= 1'b1;
          n_avg <= N_AVG_ONE;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      wen <= 1'b0;
    end
  end

  assign bus.clr_fback  = clr_fback;
  assign bus.ready      = ready;
  assign bus.wen        = wen;
  assign bus.n_avg      = n_avg;
  assign bus.avg_on_out = avg_on_out;
  assign bus.address    = address;

endmodule

// File: tb/tb_averager_counter.sv
// Directed bench for averager_counter: a vector table followed by long-run, saturation and count_max-change sequences.
// A second instance with a 4-bit slow counter shares the same stimulus so that n_avg saturation can be observed.
module tb_averager_counter;

  logic clk = 1'b0;
  logic restart;
  int   n_vec  = 0;
  int   n_fail = 0;

  averager_counter_if #(.FAST_COUNT_WIDTH(5), .SLOW_COUNT_WIDTH(10)) bus ();
  averager_counter_if #(.FAST_COUNT_WIDTH(5), .SLOW_COUNT_WIDTH(4))  bus4 ();

  averager_counter #(.FAST_COUNT_WIDTH(5), .SLOW_COUNT_WIDTH(10)) dut (
    .clk     (clk),
    .restart (restart),
    .bus     (bus)
  );

  averager_counter #(.FAST_COUNT_WIDTH(5), .SLOW_COUNT_WIDTH(4)) dut4 (
    .clk     (clk),
    .restart (restart),
    .bus     (bus4)
  );

  assign bus4.clken     = bus.clken;
  assign bus4.count_max = bus.count_max;
  assign bus4.avg_on    = bus.avg_on;

  always #5 clk = ~clk;

  typedef struct {
    logic       restart;
    logic       clken;
    logic [4:0] count_max;
    logic       avg_on;
    int         address;
    logic       wen;
    logic       clr_fback;
    logic       ready;
    int         n_avg;
    logic       avg_on_out;
  } vec_t;

  vec_t vecs[18];

  task automatic apply_stimulus(input logic r, input logic c, input logic [4:0] cm, input logic a);
    @(negedge clk);
    restart       = r;
    bus.clken     = c;
    bus.count_max = cm;
    bus.avg_on    = a;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int frames;
    int idx;

    restart       = 1'b1;
    bus.clken     = 1'b0;
    bus.count_max = 5'd3;
    bus.avg_on    = 1'b1;

    //            rst   ck    cm     avg   addr wen   clr   rdy   n  aoo
    vecs[0]  = '{1'b1, 1'b0, 5'd3, 1'b1,  0, 1'b0, 1'b1, 1'b0, 0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 5'd3, 1'b1,  0, 1'b1, 1'b1, 1'b0, 0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 5'd3, 1'b1,  4, 1'b1, 1'b1, 1'b0, 0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 5'd3, 1'b1,  4, 1'b0, 1'b1, 1'b0, 0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 5'd3, 1'b1,  8, 1'b1, 1'b1, 1'b0, 0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 5'd3, 1'b1, 12, 1'b1, 1'b1, 1'b1, 1, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 5'd3, 1'b1,  0, 1'b1, 1'b0, 1'b1, 1, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 5'd3, 1'b1,  4, 1'b1, 1'b0, 1'b1, 1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 5'd3, 1'b1,  8, 1'b1, 1'b0, 1'b1, 1, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 5'd3, 1'b1, 12, 1'b1, 1'b0, 1'b1, 2, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 5'd3, 1'b0,  0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 5'd0, 1'b1,  0, 1'b1, 1'b1, 1'b1, 1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 5'd0, 1'b1,  0, 1'b1, 1'b1, 1'b1, 1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 5'd1, 1'b1,  0, 1'b1, 1'b1, 1'b1, 1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 5'd1, 1'b1,  4, 1'b1, 1'b1, 1'b1, 1, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 5'd1, 1'b1,  0, 1'b0, 1'b1, 1'b0, 0, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 5'd1, 1'b1,  0, 1'b1, 1'b1, 1'b0, 0, 1'b1};
    vecs[17] = '{1'b1, 1'b1, 5'd1, 1'b1,  0, 1'b0, 1'b1, 1'b0, 0, 1'b1};

    for (int i = 0; i < 18; i++) begin
      apply_stimulus(vecs[i].restart, vecs[i].clken, vecs[i].count_max, vecs[i].avg_on);
      check_output($sformatf("v%0d.address", i), int'(bus.address), vecs[i].address);
      check_output($sformatf("v%0d.wen", i), int'(bus.wen), int'(vecs[i].wen));
      check_output($sformatf("v%0d.clr_fback", i), int'(bus.clr_fback), int'(vecs[i].clr_fback));
      check_output($sformatf("v%0d.ready", i), int'(bus.ready), int'(vecs[i].ready));
      check_output($sformatf("v%0d.n_avg", i), int'(bus.n_avg), vecs[i].n_avg);
      check_output($sformatf("v%0d.avg_on_out", i), int'(bus.avg_on_out), int'(vecs[i].avg_on_out));
    end

    // 100 frames of 16 samples with averaging enabled.
    apply_stimulus(1'b1, 1'b0, 5'd15, 1'b1);
    check_output("run.rst_n_avg4", int'(bus4.n_avg), 0);
    for (int i = 0; i < 1600; i++) begin
      apply_stimulus(1'b0, 1'b1, 5'd15, 1'b1);
      frames = (i + 1) / 16;
      check_output("run.address", int'(bus.address), 4 * (i % 16));
      check_output("run.wen", int'(bus.wen), 1);
      check_output("run.clr_fback", int'(bus.clr_fback), (i < 16) ? 1 : 0);
      check_output("run.ready", int'(bus.ready), (frames > 0) ? 1 : 0);
      check_output("run.n_avg", int'(bus.n_avg), frames);
      check_output("run.n_avg4", int'(bus4.n_avg), (frames > 15) ? 15 : frames);
    end
    check_output("run.n_avg_final", int'(bus.n_avg), 100);
    check_output("run.n_avg4_final", int'(bus4.n_avg), 15);

    apply_stimulus(1'b1, 1'b0, 5'd15, 1'b1);
    check_output("sat.rst_n_avg4", int'(bus4.n_avg), 0);
    check_output("sat.rst_ready4", int'(bus4.ready), 0);

    // Averaging off: every frame overwrites, so feedback is always cleared.
    apply_stimulus(1'b1, 1'b0, 5'd3, 1'b0);
    check_output("noavg.avg_on_out", int'(bus.avg_on_out), 0);
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(1'b0, 1'b1, 5'd3, 1'b1);
      check_output("noavg.address", int'(bus.address), 4 * (i % 4));
      check_output("noavg.clr_fback", int'(bus.clr_fback), 1);
      check_output("noavg.n_avg", int'(bus.n_avg), (i >= 3) ? 1 : 0);
      check_output("noavg.avg_on_out_hold", int'(bus.avg_on_out), 0);
    end

    // Restart at index 7, then lower count_max from 15 to 3 when the counter sits at 9.
    apply_stimulus(1'b1, 1'b0, 5'd15, 1'b1);
    for (int i = 0; i < 7; i++) apply_stimulus(1'b0, 1'b1, 5'd15, 1'b1);
    check_output("mid.pre_restart_addr", int'(bus.address), 24);
    apply_stimulus(1'b1, 1'b0, 5'd15, 1'b1);
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1'b0, 1'b1, 5'd15, 1'b1);
      check_output("mid.address", int'(bus.address), 4 * i);
    end
    check_output("mid.ready_before", int'(bus.ready), 0);
    apply_stimulus(1'b0, 1'b1, 5'd3, 1'b1);
    check_output("mid.last_addr", int'(bus.address), 36);
    check_output("mid.ready_after", int'(bus.ready), 1);
    check_output("mid.n_avg_after", int'(bus.n_avg), 1);
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 1'b1, 5'd3, 1'b1);
      check_output("mid.wrap_addr", int'(bus.address), 4 * idx);
      idx = (idx + 1) % 4;
    end
    check_output("mid.n_avg_final", int'(bus.n_avg), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
